// File: rtl/control_fsm_pkg.sv
// Shared definitions for the multicycle control FSM: state encoding,
// instruction classes, opcode / aluop / immediate-format constants.
package control_fsm_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        CLS_R       = 3'd0,
        CLS_I       = 3'd1,
        CLS_LOAD    = 3'd2,
        CLS_STORE   = 3'd3,
        CLS_BRANCH  = 3'd4,
        CLS_ILLEGAL = 3'd5
    } class_e;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SLL = 4'b0101;
    localparam logic [3:0] ALU_SRL = 4'b0110;
    localparam logic [3:0] ALU_SRA = 4'b0111;
    localparam logic [3:0] ALU_SLT = 4'b1000;

    localparam logic [1:0] IMM_NONE = 2'b00;
    localparam logic [1:0] IMM_I    = 2'b01;
    localparam logic [1:0] IMM_S    = 2'b10;
    localparam logic [1:0] IMM_B    = 2'b11;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    // Map the 7-bit opcode field onto an instruction class.
    function automatic class_e opcode_class(input logic [6:0] opc);
        class_e cls;
        case (opc)
            OPC_R:      cls = CLS_R;
            OPC_I:      cls = CLS_I;
            OPC_LOAD:   cls = CLS_LOAD;
            OPC_STORE:  cls = CLS_STORE;
            OPC_BRANCH: cls = CLS_BRANCH;
            default:    cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/control_fsm_alu_decoder.sv
// Combinational IR -> aluop translation. Only the opcode, funct3 and
// bit 30 (SUB/SRA selector) carry meaning here.
module alu_decoder
    import control_fsm_pkg::*;
(
    input  logic [31:0] ir,
    output logic [3:0]  aluop
);

    class_e     cls_s;
    logic [2:0] funct3_s;
    logic       unused_ir_s;

    assign cls_s       = opcode_class(ir[6:0]);
    assign funct3_s    = ir[14:12];
    assign unused_ir_s = ^{ir[31], ir[29:15], ir[11:7]};

    // Select the ALU operation from class, funct3 and IR[30].
    always_comb begin
        aluop = ALU_ADD;
        case (cls_s)
            CLS_R, CLS_I: begin
                case (funct3_s)
                    3'b000: begin
                        // Immediate forms never subtract; bit 30 is immediate data there.
                        if ((cls_s == CLS_R) && ir[30]) begin
                            aluop = ALU_SUB;
                        end else begin
                            aluop = ALU_ADD;
                        end
                    end
                    3'b001: aluop = ALU_SLL;
                    3'b010: aluop = ALU_SLT;
                    3'b011: aluop = ALU_SLT;
                    3'b100: aluop = ALU_XOR;
                    3'b101: begin
                        if (ir[30]) begin
                            aluop = ALU_SRA;
                        end else begin
                            aluop = ALU_SRL;
                        end
                    end
                    3'b110: aluop = ALU_OR;
                    3'b111: aluop = ALU_AND;
                    default: aluop = ALU_ADD;
                endcase
            end
            CLS_LOAD, CLS_STORE: aluop = ALU_ADD;
            CLS_BRANCH:          aluop = ALU_SUB;
            default:             aluop = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/control_fsm.sv
// Multicycle control FSM. The instruction is captured into IR in FETCH;
// every later state decodes from IR only, so instr never reaches an output
// combinationally. rst forces all outputs low in the cycle it is asserted,
// which also suppresses any write that the current state would issue.
module control_fsm
    import control_fsm_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic [4:0]  status,
    output logic        pcsrc,
    output logic        alusrc,
    output logic [3:0]  aluop,
    output logic        memrw,
    output logic        wb,
    output logic        regrw,
    output logic [1:0]  immgen_ctrl,
    output logic        pc_en,
    output logic        halt,
    output logic [15:0] instr_count
);

    state_e      state_r;
    state_e      state_nxt_s;
    logic [31:0] ir_r;
    logic [15:0] instr_count_r;

    class_e      cls_s;
    logic [2:0]  funct3_s;
    logic        br_legal_s;
    logic        br_taken_s;
    logic [3:0]  dec_aluop_s;
    logic        unused_status_s;

    logic        pcsrc_s;
    logic        alusrc_s;
    logic [3:0]  aluop_s;
    logic        memrw_s;
    logic        wb_s;
    logic        regrw_s;
    logic [1:0]  immgen_s;
    logic        pc_en_s;
    logic        halt_s;
    logic [15:0] instr_count_s;

    assign cls_s           = opcode_class(ir_r[6:0]);
    assign funct3_s        = ir_r[14:12];
    assign br_legal_s      = (funct3_s == F3_BEQ) || (funct3_s == F3_BNE);
    assign br_taken_s      = ((funct3_s == F3_BEQ) && status[0]) ||
                             ((funct3_s == F3_BNE) && !status[0]);
    assign unused_status_s = ^status[4:1];

    alu_decoder u_alu_decoder (
        .ir    (ir_r),
        .aluop (dec_aluop_s)
    );

    // State register with synchronous reset back to FETCH.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Instruction register: loaded only while in FETCH.
    always_ff @(posedge clk) begin
        if (rst) begin
            ir_r <= 32'd0;
        end else if (state_r == ST_FETCH) begin
            ir_r <= instr;
        end
    end

    // Retired-instruction counter; wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_count_r <= 16'd0;
        end else if (pc_en_s) begin
            instr_count_r <= instr_count_r + 16'd1;
        end
    end

    // Next-state selection per instruction class.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_FETCH: state_nxt_s = ST_DECODE;
            ST_DECODE: begin
                if (cls_s == CLS_ILLEGAL) begin
                    state_nxt_s = ST_HALT;
                end else begin
                    state_nxt_s = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (cls_s)
                    CLS_R, CLS_I:        state_nxt_s = ST_WB;
                    CLS_LOAD, CLS_STORE: state_nxt_s = ST_MEM;
                    CLS_BRANCH: begin
                        if (br_legal_s) begin
                            state_nxt_s = ST_FETCH;
                        end else begin
                            state_nxt_s = ST_HALT;
                        end
                    end
                    default: state_nxt_s = ST_HALT;
                endcase
            end
            ST_MEM: begin
                if (cls_s == CLS_LOAD) begin
                    state_nxt_s = ST_WB;
                end else begin
                    state_nxt_s = ST_FETCH;
                end
            end
            ST_WB:   state_nxt_s = ST_FETCH;
            ST_HALT: state_nxt_s = ST_HALT;
            default: state_nxt_s = ST_FETCH;
        endcase
    end

    // Output decode from state and IR; everything is held low while rst is high.
    always_comb begin
        pcsrc_s       = 1'b0;
        alusrc_s      = 1'b0;
        aluop_s       = ALU_ADD;
        memrw_s       = 1'b0;
        wb_s          = 1'b0;
        regrw_s       = 1'b0;
        immgen_s      = IMM_NONE;
        pc_en_s       = 1'b0;
        halt_s        = 1'b0;
        instr_count_s = 16'd0;
        if (rst) begin
            instr_count_s = 16'd0;
        end else begin
            instr_count_s = instr_count_r;
            case (state_r)
                ST_DECODE, ST_EXEC, ST_MEM, ST_WB: begin
                    case (cls_s)
                        CLS_R: begin
                            wb_s    = 1'b1;
                            aluop_s = dec_aluop_s;
                        end
                        CLS_I: begin
                            alusrc_s = 1'b1;
                            wb_s     = 1'b1;
                            immgen_s = IMM_I;
                            aluop_s  = dec_aluop_s;
                        end
                        CLS_LOAD: begin
                            alusrc_s = 1'b1;
                            immgen_s = IMM_I;
                            aluop_s  = dec_aluop_s;
                        end
                        CLS_STORE: begin
                            alusrc_s = 1'b1;
                            immgen_s = IMM_S;
                            aluop_s  = dec_aluop_s;
                        end
                        CLS_BRANCH: begin
                            immgen_s = IMM_B;
                            aluop_s  = dec_aluop_s;
                        end
                        default: aluop_s = ALU_ADD;
                    endcase
                    case (state_r)
                        ST_EXEC: begin
                            // A branch retires in EXEC unless its funct3 is unsupported.
                            if (cls_s == CLS_BRANCH) begin
                                pcsrc_s = br_legal_s && br_taken_s;
                                pc_en_s = br_legal_s;
                            end else begin
                                pcsrc_s = 1'b0;
                            end
                        end
                        ST_MEM: begin
                            if (cls_s == CLS_STORE) begin
                                memrw_s = 1'b1;
                                pc_en_s = 1'b1;
                            end else begin
                                memrw_s = 1'b0;
                            end
                        end
                        ST_WB: begin
                            regrw_s = 1'b1;
                            pc_en_s = 1'b1;
                        end
                        default: pc_en_s = 1'b0;
                    endcase
                end
                ST_HALT: halt_s = 1'b1;
                default: halt_s = 1'b0;
            endcase
        end
    end

    assign pcsrc       = pcsrc_s;
    assign alusrc      = alusrc_s;
    assign aluop       = aluop_s;
    assign memrw       = memrw_s;
    assign wb          = wb_s;
    assign regrw       = regrw_s;
    assign immgen_ctrl = immgen_s;
    assign pc_en       = pc_en_s;
    assign halt        = halt_s;
    assign instr_count = instr_count_s;

endmodule

// File: tb/tb_control_fsm.sv
// Scoreboard bench for control_fsm: each instruction pushes one expected
// output vector per cycle, and every cycle pops and compares one.
module tb_control_fsm;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic [4:0]  status;
    logic        pcsrc;
    logic        alusrc;
    logic [3:0]  aluop;
    logic        memrw;
    logic        wb;
    logic        regrw;
    logic [1:0]  immgen_ctrl;
    logic        pc_en;
    logic        halt;
    logic [15:0] instr_count;

    int          n_vec;
    int          n_miss;
    logic [28:0] exp_q[$];
    logic [15:0] exp_count;
    logic [28:0] dut_vec;

    control_fsm dut (
        .clk         (clk),
        .rst         (rst),
        .instr       (instr),
        .status      (status),
        .pcsrc       (pcsrc),
        .alusrc      (alusrc),
        .aluop       (aluop),
        .memrw       (memrw),
        .wb          (wb),
        .regrw       (regrw),
        .immgen_ctrl (immgen_ctrl),
        .pc_en       (pc_en),
        .halt        (halt),
        .instr_count (instr_count)
    );

    assign dut_vec = {pcsrc, alusrc, aluop, memrw, wb, regrw, immgen_ctrl, pc_en, halt, instr_count};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference aluop table for R / I-ALU instructions.
    function automatic logic [3:0] ref_aluop(input logic [2:0] f3, input logic b30, input bit is_r);
        logic [3:0] op;
        case (f3)
            3'd0:    op = (is_r && b30) ? 4'b0001 : 4'b0000;
            3'd1:    op = 4'b0101;
            3'd2:    op = 4'b1000;
            3'd3:    op = 4'b1000;
            3'd4:    op = 4'b0100;
            3'd5:    op = b30 ? 4'b0111 : 4'b0110;
            3'd6:    op = 4'b0011;
            default: op = 4'b0010;
        endcase
        return op;
    endfunction

    // Expected outputs; stt: 0 FETCH, 1 DECODE, 2 EXEC, 3 MEM, 4 WB, 5 HALT.
    function automatic logic [28:0] model(input logic [31:0] ins, input logic [4:0] st,
                                          input int stt, input logic [15:0] cnt);
        logic       p, as, mw, w, rw, pe, h;
        logic [3:0] op;
        logic [1:0] im;
        logic [2:0] f3;
        {p, as, mw, w, rw, pe, h} = 7'd0;
        op = 4'd0;
        im = 2'd0;
        f3 = ins[14:12];
        if (stt == 5) begin
            h = 1'b1;
        end else if (stt != 0) begin
            case (ins[6:0])
                7'h33: begin w = 1'b1; op = ref_aluop(f3, ins[30], 1'b1); end
                7'h13: begin as = 1'b1; w = 1'b1; im = 2'b01; op = ref_aluop(f3, ins[30], 1'b0); end
                7'h03: begin as = 1'b1; im = 2'b01; end
                7'h23: begin
                    as = 1'b1; im = 2'b10;
                    if (stt == 3) begin mw = 1'b1; pe = 1'b1; end
                end
                7'h63: begin
                    im = 2'b11; op = 4'b0001;
                    if (stt == 2) begin
                        p  = ((f3 == 3'd0) && st[0]) || ((f3 == 3'd1) && !st[0]);
                        pe = (f3 == 3'd0) || (f3 == 3'd1);
                    end
                end
                default: ;
            endcase
            if (stt == 4) begin rw = 1'b1; pe = 1'b1; end
        end
        return {p, as, op, mw, w, rw, im, pe, h, cnt};
    endfunction

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst   = 1'b1;
            instr = $urandom;
            #1;
            check_eq("reset", {3'd0, dut_vec}, 32'd0);
        end
        exp_count = 16'd0;
    endtask

    // Run one instruction from FETCH; abort_idx asserts rst in that cycle.
    task automatic run_instr(input string tag, input logic [31:0] ins, input logic [4:0] st,
                             input bit preset, input int abort_idx);
        int   path[$];
        bit   retires;
        int   n;
        logic [28:0] exp;
        retires = 1'b1;
        path.push_back(0);
        path.push_back(1);
        case (ins[6:0])
            7'h33, 7'h13: begin path.push_back(2); path.push_back(4); end
            7'h03:        begin path.push_back(2); path.push_back(3); path.push_back(4); end
            7'h23:        begin path.push_back(2); path.push_back(3); end
            7'h63: begin
                path.push_back(2);
                if (ins[14:13] != 2'b00) begin
                    retires = 1'b0;
                    for (int k = 0; k < 3; k++) path.push_back(5);
                end
            end
            default: begin
                retires = 1'b0;
                for (int k = 0; k < 10; k++) path.push_back(5);
            end
        endcase
        if (preset) exp_count = 16'hFFFF;
        n = 0;
        foreach (path[i]) begin
            if (i == abort_idx) begin
                exp_q.push_back(29'd0);
                n++;
                break;
            end
            exp_q.push_back(model(ins, st, path[i], exp_count));
            n++;
        end
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0) begin
                rst    = 1'b0;
                instr  = ins;
                status = st;
                if (preset) begin
                    force dut.instr_count_r = 16'hFFFF;
                    #1;
                    release dut.instr_count_r;
                end
            end else begin
                instr = ~ins;
            end
            if (i == abort_idx) rst = 1'b1;
            #1;
            exp = exp_q.pop_front();
            check_eq($sformatf("%s c%0d", tag, i + 1), {3'd0, dut_vec}, {3'd0, exp});
        end
        if (abort_idx >= 0) begin
            exp_count = 16'd0;
        end else if (retires) begin
            exp_count = exp_count + 16'd1;
        end
    endtask

    initial begin
        n_vec     = 0;
        n_miss    = 0;
        exp_count = 16'd0;
        rst       = 1'b1;
        instr     = 32'd0;
        status    = 5'd0;
        do_reset(3);
        run_instr("add",      32'h002081B3, 5'b00000, 1'b0, -1);
        run_instr("sub",      32'h402081B3, 5'b00000, 1'b0, -1);
        run_instr("addi",     32'h00500093, 5'b00000, 1'b0, -1);
        run_instr("srai",     32'h4030D093, 5'b00000, 1'b0, -1);
        run_instr("xor",      32'h0020C1B3, 5'b00000, 1'b0, -1);
        run_instr("sw",       32'h0020A423, 5'b00000, 1'b0, -1);
        run_instr("lw",       32'h0080A183, 5'b00000, 1'b0, -1);
        run_instr("beq_t",    32'h00208463, 5'b00001, 1'b0, -1);
        run_instr("beq_nt",   32'h00208463, 5'b00000, 1'b0, -1);
        run_instr("bne_t",    32'h00209463, 5'b00000, 1'b0, -1);
        run_instr("illegal",  32'h0000007F, 5'b00000, 1'b0, -1);
        do_reset(2);
        run_instr("blt_halt", 32'h0020C463, 5'b00001, 1'b0, -1);
        do_reset(1);
        run_instr("sw_abort", 32'h0020A423, 5'b00000, 1'b0, 3);
        run_instr("wrap_beq", 32'h00208463, 5'b00001, 1'b1, -1);
        run_instr("add_post", 32'h002081B3, 5'b00000, 1'b0, -1);
        run_instr("add_cnt",  32'h002081B3, 5'b00000, 1'b0, -1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
